// File: rtl/regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter
//
// Shares the single register-file write port between three requesters:
//   WB  - ALU/load writeback
//   UPD - base-register update
//   PC  - next-PC write (always to r(NREGS-1))
// Also holds the per-register pending (scoreboard) bits and produces the
// issue-stage hazard stall.
//
// Arbitration: WB > UPD > PC by default. A requester refused for MAX_WAIT
// consecutive cycles becomes urgent and jumps above WB (UPD before PC).
// PC is ineligible while pending[NREGS-1] is set.
//
// Ports
//   i_clk, i_reset_n                      clock, async active-low reset
//   i_wb_valid/o_wb_ready/i_wb_addr/i_wb_data      WB request channel
//   i_upd_valid/o_upd_ready/i_upd_addr/i_upd_data  UPD request channel
//   i_pc_valid/o_pc_ready/i_pc_data                PC request channel
//   i_sb_set, i_sb_set_addr               mark a register pending
//   i_chk_en[3:0] = {dest,src3,src2,src1}, i_chk_*   hazard check addresses
//   o_stall                               combinational hazard
//   o_rf_we/o_rf_waddr/o_rf_wdata         registered write port
//   o_pending                             registered scoreboard bits
// ---------------------------------------------------------------------------
module regfile_write_arbiter #(
  parameter int DATA_W   = 32,
  parameter int NREGS    = 16,
  parameter int ADDR_W   = 4,
  parameter int MAX_WAIT = 4
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  // writeback requester
  input  logic              i_wb_valid,
  output logic              o_wb_ready,
  input  logic [ADDR_W-1:0] i_wb_addr,
  input  logic [DATA_W-1:0] i_wb_data,
  // base-register update requester
  input  logic              i_upd_valid,
  output logic              o_upd_ready,
  input  logic [ADDR_W-1:0] i_upd_addr,
  input  logic [DATA_W-1:0] i_upd_data,
  // next-PC requester
  input  logic              i_pc_valid,
  output logic              o_pc_ready,
  input  logic [DATA_W-1:0] i_pc_data,
  // scoreboard set from issue
  input  logic              i_sb_set,
  input  logic [ADDR_W-1:0] i_sb_set_addr,
  // hazard check
  input  logic [3:0]        i_chk_en,
  input  logic [ADDR_W-1:0] i_chk_src1,
  input  logic [ADDR_W-1:0] i_chk_src2,
  input  logic [ADDR_W-1:0] i_chk_src3,
  input  logic [ADDR_W-1:0] i_chk_dest,
  output logic              o_stall,
  // register file write port
  output logic              o_rf_we,
  output logic [ADDR_W-1:0] o_rf_waddr,
  output logic [DATA_W-1:0] o_rf_wdata,
  output logic [NREGS-1:0]  o_pending
);

  localparam int              CNT_W   = 4;
  localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_WAIT);
  localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(NREGS - 1);

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_WB   = 2'd1,
    GNT_UPD  = 2'd2,
    GNT_PC   = 2'd3
  } gnt_e;

  logic [CNT_W-1:0]  r_wait_upd;
  logic [CNT_W-1:0]  r_wait_pc;
  logic [NREGS-1:0]  r_pending;
  logic              r_rf_we;
  logic [ADDR_W-1:0] r_rf_waddr;
  logic [DATA_W-1:0] r_rf_wdata;

  gnt_e              w_gnt;
  logic              w_gnt_any;
  logic [ADDR_W-1:0] w_gnt_addr;
  logic [DATA_W-1:0] w_gnt_data;
  logic              w_pc_elig;
  logic              w_upd_urgent;
  logic              w_pc_urgent;
  logic [CNT_W-1:0]  w_wait_upd_nxt;
  logic [CNT_W-1:0]  w_wait_pc_nxt;
  logic [NREGS-1:0]  w_pending_nxt;
  logic              w_stall;

  // PC may not write while a PC-writing op is still in flight.
  assign w_pc_elig    = i_pc_valid && !r_pending[PC_ADDR];
  assign w_upd_urgent = i_upd_valid && (r_wait_upd == MAX_C);
  assign w_pc_urgent  = w_pc_elig && (r_wait_pc == MAX_C);

  // -------------------------------------------------------------------------
  // Grant selection
  // -------------------------------------------------------------------------
  always_comb begin
    w_gnt = GNT_NONE;
    if (w_upd_urgent) begin
      w_gnt = GNT_UPD;
    end else if (w_pc_urgent) begin
      w_gnt = GNT_PC;
    end else if (i_wb_valid) begin
      w_gnt = GNT_WB;
    end else if (i_upd_valid) begin
      w_gnt = GNT_UPD;
    end else if (w_pc_elig) begin
      w_gnt = GNT_PC;
    end
  end

  always_comb begin
    w_gnt_addr = '0;
    w_gnt_data = '0;
    case (w_gnt)
      GNT_WB: begin
        w_gnt_addr = i_wb_addr;
        w_gnt_data = i_wb_data;
      end
      GNT_UPD: begin
        w_gnt_addr = i_upd_addr;
        w_gnt_data = i_upd_data;
      end
      GNT_PC: begin
        w_gnt_addr = PC_ADDR;
        w_gnt_data = i_pc_data;
      end
      default: begin
        w_gnt_addr = '0;
        w_gnt_data = '0;
      end
    endcase
  end

  assign w_gnt_any   = (w_gnt != GNT_NONE);
  assign o_wb_ready  = (w_gnt == GNT_WB);
  assign o_upd_ready = (w_gnt == GNT_UPD);
  assign o_pc_ready  = (w_gnt == GNT_PC);

  // -------------------------------------------------------------------------
  // Starvation counters
  // -------------------------------------------------------------------------
  always_comb begin
    w_wait_upd_nxt = r_wait_upd;
    if (!i_upd_valid || (w_gnt == GNT_UPD)) begin
      w_wait_upd_nxt = '0;
    end else if (r_wait_upd != MAX_C) begin
      w_wait_upd_nxt = r_wait_upd + 1'b1;
    end
  end

  // While PC is ineligible the count freezes rather than clearing, so a PC
  // request that was already starving keeps its standing once eligible.
  always_comb begin
    w_wait_pc_nxt = r_wait_pc;
    if (!i_pc_valid || (w_gnt == GNT_PC)) begin
      w_wait_pc_nxt = '0;
    end else if (w_pc_elig && (r_wait_pc != MAX_C)) begin
      w_wait_pc_nxt = r_wait_pc + 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Scoreboard: clear the granted register first, then apply the issue set so
  // that a same-cycle clear and set leaves the register pending.
  // -------------------------------------------------------------------------
  always_comb begin
    w_pending_nxt = r_pending;
    if (w_gnt_any) begin
      w_pending_nxt[w_gnt_addr] = 1'b0;
    end
    if (i_sb_set) begin
      w_pending_nxt[i_sb_set_addr] = 1'b1;
    end
  end

  // Stall looks only at registered pending; a grant in this cycle does not
  // release a hazard until the write is visible on the register file.
  always_comb begin
    w_stall = 1'b0;
    if (i_chk_en[0] && r_pending[i_chk_src1]) w_stall = 1'b1;
    if (i_chk_en[1] && r_pending[i_chk_src2]) w_stall = 1'b1;
    if (i_chk_en[2] && r_pending[i_chk_src3]) w_stall = 1'b1;
    if (i_chk_en[3] && r_pending[i_chk_dest]) w_stall = 1'b1;
  end

  assign o_stall = w_stall;

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wait_upd <= '0;
      r_wait_pc  <= '0;
      r_pending  <= '0;
    end else begin
      r_wait_upd <= w_wait_upd_nxt;
      r_wait_pc  <= w_wait_pc_nxt;
      r_pending  <= w_pending_nxt;
    end
  end

  // Address/data hold their last value when idle; only rf_we qualifies them.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rf_we    <= 1'b0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
    end else begin
      r_rf_we <= w_gnt_any;
      if (w_gnt_any) begin
        r_rf_waddr <= w_gnt_addr;
        r_rf_wdata <= w_gnt_data;
      end
    end
  end

  assign o_rf_we    = r_rf_we;
  assign o_rf_waddr = r_rf_waddr;
  assign o_rf_wdata = r_rf_wdata;
  assign o_pending  = r_pending;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

  localparam int MAXW = 4;

  logic        i_clk;
  logic        i_reset_n;
  logic        i_wb_valid;
  logic        o_wb_ready;
  logic [3:0]  i_wb_addr;
  logic [31:0] i_wb_data;
  logic        i_upd_valid;
  logic        o_upd_ready;
  logic [3:0]  i_upd_addr;
  logic [31:0] i_upd_data;
  logic        i_pc_valid;
  logic        o_pc_ready;
  logic [31:0] i_pc_data;
  logic        i_sb_set;
  logic [3:0]  i_sb_set_addr;
  logic [3:0]  i_chk_en;
  logic [3:0]  i_chk_src1;
  logic [3:0]  i_chk_src2;
  logic [3:0]  i_chk_src3;
  logic [3:0]  i_chk_dest;
  logic        o_stall;
  logic        o_rf_we;
  logic [3:0]  o_rf_waddr;
  logic [31:0] o_rf_wdata;
  logic [15:0] o_pending;

  regfile_write_arbiter #(
    .DATA_W(32), .NREGS(16), .ADDR_W(4), .MAX_WAIT(MAXW)
  ) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_wb_valid(i_wb_valid), .o_wb_ready(o_wb_ready),
    .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
    .i_upd_valid(i_upd_valid), .o_upd_ready(o_upd_ready),
    .i_upd_addr(i_upd_addr), .i_upd_data(i_upd_data),
    .i_pc_valid(i_pc_valid), .o_pc_ready(o_pc_ready), .i_pc_data(i_pc_data),
    .i_sb_set(i_sb_set), .i_sb_set_addr(i_sb_set_addr),
    .i_chk_en(i_chk_en), .i_chk_src1(i_chk_src1), .i_chk_src2(i_chk_src2),
    .i_chk_src3(i_chk_src3), .i_chk_dest(i_chk_dest), .o_stall(o_stall),
    .o_rf_we(o_rf_we), .o_rf_waddr(o_rf_waddr), .o_rf_wdata(o_rf_wdata),
    .o_pending(o_pending)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [15:0] m_pend;
  int          m_wu, m_wp;
  logic        m_we;
  logic [3:0]  m_waddr;
  logic [31:0] m_wdata;
  int          last_g;     // 0 none, 1 WB, 2 UPD, 3 PC
  int          cap_g;      // grant observed on DUT readys

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = '0; m_wu = 0; m_wp = 0;
    m_we = 1'b0; m_waddr = '0; m_wdata = '0;
    last_g = 0;
  endtask

  task automatic idle_inputs();
    i_wb_valid = 0; i_wb_addr = 0; i_wb_data = 0;
    i_upd_valid = 0; i_upd_addr = 0; i_upd_data = 0;
    i_pc_valid = 0; i_pc_data = 0;
    i_sb_set = 0; i_sb_set_addr = 0;
    i_chk_en = 0; i_chk_src1 = 0; i_chk_src2 = 0; i_chk_src3 = 0; i_chk_dest = 0;
  endtask

  // One clock: inputs already driven (shortly after a rising edge).
  // Mid-cycle: compare readys/stall. After edge: compare registered outputs.
  task automatic cycle();
    int g;
    logic pc_ok, exp_stall;
    logic [3:0] ga;
    logic [31:0] gd;
    #4;
    pc_ok = i_pc_valid && !m_pend[15];
    g = 0;
    if (i_upd_valid && m_wu == MAXW)      g = 2;
    else if (pc_ok && m_wp == MAXW)       g = 3;
    else if (i_wb_valid)                  g = 1;
    else if (i_upd_valid)                 g = 2;
    else if (pc_ok)                       g = 3;
    ga = (g == 1) ? i_wb_addr : (g == 2) ? i_upd_addr : 4'd15;
    gd = (g == 1) ? i_wb_data : (g == 2) ? i_upd_data : i_pc_data;
    exp_stall = (i_chk_en[0] && m_pend[i_chk_src1]) || (i_chk_en[1] && m_pend[i_chk_src2]) ||
                (i_chk_en[2] && m_pend[i_chk_src3]) || (i_chk_en[3] && m_pend[i_chk_dest]);
    cap_g = o_wb_ready ? 1 : o_upd_ready ? 2 : o_pc_ready ? 3 : 0;
    chk("wb_ready",  o_wb_ready,  g == 1);
    chk("upd_ready", o_upd_ready, g == 2);
    chk("pc_ready",  o_pc_ready,  g == 3);
    chk("stall",     o_stall,     exp_stall);
    @(posedge i_clk);
    if (g != 0) m_pend[ga] = 1'b0;
    if (i_sb_set) m_pend[i_sb_set_addr] = 1'b1;
    if (!i_upd_valid || g == 2) m_wu = 0;
    else if (m_wu < MAXW) m_wu++;
    if (!i_pc_valid || g == 3) m_wp = 0;
    else if (pc_ok && m_wp < MAXW) m_wp++;
    m_we = (g != 0);
    if (g != 0) begin m_waddr = ga; m_wdata = gd; end
    last_g = g;
    #1;
    chk("rf_we",   o_rf_we,   m_we);
    chk("pending", o_pending, m_pend);
    if (m_we) begin
      chk("rf_waddr", o_rf_waddr, m_waddr);
      chk("rf_wdata", o_rf_wdata, m_wdata);
    end
  endtask

  initial begin
    idle_inputs();
    model_reset();
    i_reset_n = 0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_rf_we",    o_rf_we,    1'b0);
    chk("rst_rf_waddr", o_rf_waddr, 4'd0);
    chk("rst_rf_wdata", o_rf_wdata, 32'd0);
    chk("rst_pending",  o_pending,  16'd0);
    i_wb_valid = 1;
    #1 chk("rst_wb_ready_follows", o_wb_ready, 1'b1);
    i_wb_valid = 0;
    @(posedge i_clk); #1;
    i_reset_n = 1;

    // single WB r3 = 0x1234
    i_wb_valid = 1; i_wb_addr = 3; i_wb_data = 32'h1234;
    cycle();
    chk("wb1_granted", cap_g, 1);
    chk("wb1_addr", o_rf_waddr, 4'd3);
    chk("wb1_data", o_rf_wdata, 32'h1234);
    idle_inputs();
    cycle();
    chk("wb1_we_one_cycle", o_rf_we, 1'b0);

    // starvation: WB, UPD, PC all requesting -> WB x4, UPD, PC
    begin
      int exp_seq[6] = '{1, 1, 1, 1, 2, 3};
      i_upd_valid = 1; i_upd_addr = 2; i_upd_data = 32'hAAAA0002;
      i_pc_valid = 1; i_pc_data = 32'h0000_0100;
      for (int k = 0; k < 6; k++) begin
        i_wb_valid = 1; i_wb_addr = 1; i_wb_data = 32'h1000 + 32'(k);
        cycle();
        chk("starve_seq", cap_g, exp_seq[k]);
        if (cap_g == 2) i_upd_valid = 0;
        if (cap_g == 3) i_pc_valid = 0;
      end
      idle_inputs();
      cycle();
    end

    // sb_set r5, check src1=5
    i_sb_set = 1; i_sb_set_addr = 5; i_chk_en = 4'b0001; i_chk_src1 = 5;
    cycle();
    i_sb_set = 0;
    cycle();
    chk("sb5_stall", o_stall, 1'b1);
    i_wb_valid = 1; i_wb_addr = 5; i_wb_data = 32'h55;
    cycle();
    i_wb_valid = 0;
    #4 chk("sb5_stall_released", o_stall, 1'b0);
    @(posedge i_clk); #1;
    cycle();

    // same-cycle clear and set of r7
    i_sb_set = 1; i_sb_set_addr = 7;
    cycle();
    i_wb_valid = 1; i_wb_addr = 7; i_wb_data = 32'h77;
    cycle();
    chk("r7_set_wins", o_pending[7], 1'b1);
    idle_inputs();
    i_chk_en = 4'b0010; i_chk_src2 = 7;
    cycle();
    chk("r7_stall_src2", o_stall, 1'b1);
    idle_inputs();

    // PC blocked by pending[15]
    i_sb_set = 1; i_sb_set_addr = 15;
    cycle();
    i_sb_set = 0;
    i_pc_valid = 1; i_pc_data = 32'h2000;
    cycle();
    chk("pc_blocked", cap_g, 0);
    i_wb_valid = 1; i_wb_addr = 15; i_wb_data = 32'hF0;
    cycle();
    chk("wb_r15", cap_g, 1);
    i_wb_valid = 0;
    cycle();
    chk("pc_after_clear", cap_g, 3);
    idle_inputs();
    cycle();

    // reset during UPD wait
    i_sb_set = 1; i_sb_set_addr = 9;
    cycle();
    i_sb_set = 0;
    i_upd_valid = 1; i_upd_addr = 2; i_upd_data = 32'hBEEF;
    for (int k = 0; k < 2; k++) begin
      i_wb_valid = 1; i_wb_addr = 4; i_wb_data = 32'h40 + 32'(k);
      cycle();
    end
    i_reset_n = 0;
    #1;
    chk("midrst_rf_we",   o_rf_we,   1'b0);
    chk("midrst_pending", o_pending, 16'd0);
    #1;
    i_reset_n = 1;
    model_reset();
    i_wb_valid = 0;
    cycle();
    chk("upd_after_rst", cap_g, 2);
    idle_inputs();
    cycle();

    // randomized traffic against the model, obeying the hold rule
    for (int n = 0; n < 500; n++) begin
      if (!i_wb_valid || last_g == 1) begin
        i_wb_valid = ($urandom_range(0, 2) != 0);
        i_wb_addr = 4'($urandom_range(0, 15));
        i_wb_data = $urandom;
      end
      if (!i_upd_valid || last_g == 2) begin
        i_upd_valid = ($urandom_range(0, 2) == 0);
        i_upd_addr = 4'($urandom_range(0, 15));
        i_upd_data = $urandom;
      end
      if (!i_pc_valid || last_g == 3) begin
        i_pc_valid = ($urandom_range(0, 2) == 0);
        i_pc_data = $urandom;
      end
      i_sb_set = ($urandom_range(0, 3) == 0);
      i_sb_set_addr = 4'($urandom_range(0, 15));
      i_chk_en = 4'($urandom_range(0, 15));
      i_chk_src1 = 4'($urandom_range(0, 15));
      i_chk_src2 = 4'($urandom_range(0, 15));
      i_chk_src3 = 4'($urandom_range(0, 15));
      i_chk_dest = 4'($urandom_range(0, 15));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
